// File: rtl/rx_controller_if.sv
// Consumer-side character handshake of the UART receive controller.
// The controller drives the FIFO head and valid; the consumer answers with ready.
interface rx_controller_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/rx_controller.sv
// UART receive sequencer: start-bit qualification, mid-bit shift strobes, stop check,
// and a small character FIFO toward the consumer.
//
//  state | meaning
//  IDLE  | line idle, waiting for a falling edge
//  START | timing to the middle of the start bit to reject glitches
//  DATA  | strobing the external shift register once per bit period
//  STOP  | timing to the middle of the stop bit
//  BRK   | stop bit was 0, waiting for the line to return high
module rx_controller #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_data_in,
    input  logic [DATA_BITS-1:0] i_stp_data,
    output logic                 o_shift_en,
    output logic                 o_character_received,
    output logic                 o_framing_error,
    output logic                 o_overrun,
    input  logic                 i_overrun_clr,
    output logic                 o_busy,
    rx_controller_if.master      rx
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int IDX_W  = $clog2(DATA_BITS + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [FCNT_W-1:0]    r_count;
    logic                 r_overrun;

    logic w_half_bit;
    logic w_bit_end;
    logic w_stop_smp;
    logic w_push;
    logic w_pop;
    logic w_full;
    logic w_push_ok;
    logic w_drop;
    logic w_valid;

    assign w_half_bit = (r_cnt == CNT_W'(OVERSAMPLE / 2 - 1));
    assign w_bit_end  = (r_cnt == CNT_W'(OVERSAMPLE - 1));
    assign w_stop_smp = (r_state == STOP) && w_bit_end;
    assign w_push     = w_stop_smp && i_data_in;
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && rx.rx_ready;
    assign w_full     = (r_count == FCNT_W'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!i_data_in) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (w_half_bit) begin
                        r_cnt <= '0;
                        if (!i_data_in) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                        if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= i_data_in ? IDLE : BRK;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                BRK: begin
                    if (i_data_in) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + FCNT_W'(1);
                2'b01:   r_count <= r_count - FCNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_stp_data;
        end
    end

    // Strobes are decoded in the sampling cycle itself so the shift register and the
    // FIFO push see data_in and stp_data at exactly the mid-bit point.
    assign o_shift_en           = (r_state == DATA) && w_bit_end;
    assign o_character_received = w_push;
    assign o_framing_error      = w_stop_smp && !i_data_in;
    assign o_overrun            = r_overrun;
    assign o_busy               = (r_state != IDLE);
    assign rx.rx_valid          = w_valid;
    assign rx.rx_data           = w_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: tb/tb_rx_controller.sv
// Directed bench for rx_controller: frames are driven cycle-by-cycle, outputs are logged
// per cycle (cycle 0 = first START cycle) and checked against hand-derived timing.
module tb_rx_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_in;
    logic       overrun_clr;
    logic [7:0] sr;
    logic       shift_en, cr, fe, overrun, busy;

    int checks = 0;
    int errors = 0;

    logic       a_shift [0:399];
    logic       a_cr    [0:399];
    logic       a_fe    [0:399];
    logic       a_ovr   [0:399];
    logic       a_valid [0:399];
    logic       a_busy  [0:399];
    logic [7:0] a_data  [0:399];
    int n_shift, n_cr, n_fe, n_valid;

    rx_controller_if #(.DATA_BITS(8)) rxi ();

    rx_controller #(.OVERSAMPLE(16), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_data_in            (data_in),
        .i_stp_data           (sr),
        .o_shift_en           (shift_en),
        .o_character_received (cr),
        .o_framing_error      (fe),
        .o_overrun            (overrun),
        .i_overrun_clr        (overrun_clr),
        .o_busy               (busy),
        .rx                   (rxi)
    );

    always #5 clk = ~clk;

    // External serial_to_parallel: LSB arrives first, so shift toward bit 0.
    always @(posedge clk) begin
        if (shift_en) sr <= {data_in, sr[7:1]};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic line_val(int cyc, logic [7:0] d, bit stop, int low_extra, int high_after);
        int b;
        if (high_after >= 0 && cyc > high_after) return 1'b1;
        b = (cyc + 1) / 16;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return stop;
        if (!stop && cyc < 159 + low_extra) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [7:0] d, input bit stop, input int low_extra,
                             input int high_after, input int rst_at, input int pop_at, input int ncyc);
        n_shift = 0; n_cr = 0; n_fe = 0; n_valid = 0;
        for (int i = 0; i < 400; i++) begin
            a_shift[i] = 0; a_cr[i] = 0; a_fe[i] = 0; a_ovr[i] = 0;
            a_valid[i] = 0; a_busy[i] = 0; a_data[i] = 8'h00;
        end
        for (int cyc = -1; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            data_in = line_val(cyc, d, stop, low_extra, high_after);
            rst = (rst_at >= 0 && cyc == rst_at);
            if (pop_at >= 0) rxi.rx_ready = (cyc == pop_at);
            @(negedge clk);
            if (cyc >= 0) begin
                a_shift[cyc] = shift_en; a_cr[cyc] = cr; a_fe[cyc] = fe; a_ovr[cyc] = overrun;
                a_valid[cyc] = rxi.rx_valid; a_busy[cyc] = busy; a_data[cyc] = rxi.rx_data;
                if (shift_en) n_shift++;
                if (cr) n_cr++;
                if (fe) n_fe++;
                if (rxi.rx_valid) n_valid++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; data_in = 1'b1; rxi.rx_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({shift_en, cr, fe, overrun, busy, rxi.rx_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000", {shift_en, cr, fe, overrun, busy, rxi.rx_valid});
        end
        checks++;
        if (rxi.rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_rx_data: got %h expected 00", rxi.rx_data);
        end
    endtask

    task automatic test_frame();
        rxi.rx_ready = 1'b1;
        run_frame(8'hA5, 1'b1, 0, -1, -1, -1, 170);
        checks++;
        if (n_shift !== 8) begin errors++; $display("FAIL frame_shift_count: got %0d expected 8", n_shift); end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (a_shift[23 + 16*k] !== 1'b1) begin
                errors++; $display("FAIL frame_shift_at_%0d: got %b expected 1", 23 + 16*k, a_shift[23 + 16*k]);
            end
        end
        checks++;
        if (a_cr[151] !== 1'b1 || n_cr !== 1) begin
            errors++; $display("FAIL frame_char_rcv: got @151=%b count=%0d expected 1/1", a_cr[151], n_cr);
        end
        checks++;
        if (n_fe !== 0) begin errors++; $display("FAIL frame_no_fe: got %0d expected 0", n_fe); end
        checks++;
        if ({a_valid[151], a_valid[152], a_valid[153]} !== 3'b010) begin
            errors++; $display("FAIL frame_rx_valid: got %b expected 010", {a_valid[151], a_valid[152], a_valid[153]});
        end
        checks++;
        if (a_data[152] !== 8'hA5) begin errors++; $display("FAIL frame_rx_data: got %h expected a5", a_data[152]); end
        checks++;
        if ({a_busy[0], a_busy[151], a_busy[152]} !== 3'b110) begin
            errors++; $display("FAIL frame_busy: got %b expected 110", {a_busy[0], a_busy[151], a_busy[152]});
        end
    endtask

    task automatic test_glitch();
        run_frame(8'h00, 1'b1, 0, 2, -1, -1, 30);
        checks++;
        if ({a_busy[7], a_busy[8]} !== 2'b10) begin
            errors++; $display("FAIL glitch_busy: got %b expected 10", {a_busy[7], a_busy[8]});
        end
        checks++;
        if (n_shift !== 0 || n_cr !== 0 || n_fe !== 0) begin
            errors++; $display("FAIL glitch_no_strobes: got shift=%0d cr=%0d fe=%0d expected 0/0/0", n_shift, n_cr, n_fe);
        end
    endtask

    task automatic test_framing();
        rxi.rx_ready = 1'b1;
        run_frame(8'h3C, 1'b0, 40, -1, -1, -1, 210);
        checks++;
        if (a_fe[151] !== 1'b1 || n_fe !== 1) begin
            errors++; $display("FAIL framing_fe: got @151=%b count=%0d expected 1/1", a_fe[151], n_fe);
        end
        checks++;
        if (n_cr !== 0 || n_valid !== 0) begin
            errors++; $display("FAIL framing_no_push: got cr=%0d valid=%0d expected 0/0", n_cr, n_valid);
        end
        checks++;
        if ({a_busy[198], a_busy[199], a_busy[200]} !== 3'b110) begin
            errors++; $display("FAIL framing_break_exit: got %b expected 110", {a_busy[198], a_busy[199], a_busy[200]});
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03; exp_q[3] = 8'h04;
        rxi.rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            run_frame(8'(i), 1'b1, 0, -1, -1, -1, 160);
            if (i == 4) begin
                checks++;
                if (a_ovr[159] !== 1'b0) begin errors++; $display("FAIL ovr_not_yet: got %b expected 0", a_ovr[159]); end
            end
        end
        checks++;
        if ({a_cr[151], a_ovr[151], a_ovr[152]} !== 3'b101) begin
            errors++; $display("FAIL ovr_drop: got cr/ovr151/ovr152=%b expected 101", {a_cr[151], a_ovr[151], a_ovr[152]});
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxi.rx_valid !== 1'b1 || rxi.rx_data !== exp_q[i]) begin
                errors++; $display("FAIL ovr_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, rxi.rx_valid, rxi.rx_data, exp_q[i]);
            end
            rxi.rx_ready = 1'b1;
            @(negedge clk);
        end
        rxi.rx_ready = 1'b0;
        checks++;
        if (rxi.rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b expected 0", rxi.rx_valid); end
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_q [4];
        exp_q[0] = 8'h12; exp_q[1] = 8'h13; exp_q[2] = 8'h14; exp_q[3] = 8'h55;
        rxi.rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_frame(8'h11 + 8'(i), 1'b1, 0, -1, -1, -1, 160);
        run_frame(8'h55, 1'b1, 0, -1, -1, 151, 160);
        checks++;
        if ({a_cr[151], a_ovr[152], overrun} !== 3'b100) begin
            errors++; $display("FAIL fullpop_no_ovr: got cr/ovr152/ovr=%b expected 100", {a_cr[151], a_ovr[152], overrun});
        end
        checks++;
        if (a_data[151] !== 8'h11 || a_data[152] !== 8'h12) begin
            errors++; $display("FAIL fullpop_head: got %h,%h expected 11,12", a_data[151], a_data[152]);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rxi.rx_valid !== 1'b1 || rxi.rx_data !== exp_q[i]) begin
                errors++; $display("FAIL fullpop_drain_%0d: got v=%b d=%h expected v=1 d=%h", i, rxi.rx_valid, rxi.rx_data, exp_q[i]);
            end
            rxi.rx_ready = 1'b1;
            @(negedge clk);
        end
        rxi.rx_ready = 1'b0;
        checks++;
        if (rxi.rx_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty: got %b expected 0", rxi.rx_valid); end
    endtask

    task automatic test_reset_midframe();
        rxi.rx_ready = 1'b0;
        run_frame(8'h42, 1'b1, 0, -1, -1, -1, 160);
        checks++;
        if (rxi.rx_valid !== 1'b1 || rxi.rx_data !== 8'h42) begin
            errors++; $display("FAIL midrst_prefill: got v=%b d=%h expected v=1 d=42", rxi.rx_valid, rxi.rx_data);
        end
        run_frame(8'hE7, 1'b1, 0, 60, 60, -1, 80);
        checks++;
        if (a_busy[60] !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", a_busy[60]); end
        checks++;
        if ({a_shift[61], a_cr[61], a_fe[61], a_ovr[61], a_busy[61], a_valid[61]} !== 6'b0 || a_data[61] !== 8'h00) begin
            errors++;
            $display("FAIL midrst_outputs: got %b data=%h expected 000000 data=00",
                     {a_shift[61], a_cr[61], a_fe[61], a_ovr[61], a_busy[61], a_valid[61]}, a_data[61]);
        end
        rxi.rx_ready = 1'b1;
        run_frame(8'h0F, 1'b1, 0, -1, -1, -1, 170);
        checks++;
        if (a_valid[0] !== 1'b0 || n_shift !== 8) begin
            errors++; $display("FAIL midrst_after_state: got valid0=%b shifts=%0d expected 0/8", a_valid[0], n_shift);
        end
        checks++;
        if (a_valid[152] !== 1'b1 || a_data[152] !== 8'h0F) begin
            errors++; $display("FAIL midrst_next_frame: got v=%b d=%h expected v=1 d=0f", a_valid[152], a_data[152]);
        end
    endtask

    initial begin
        sr = 8'h00;
        test_reset();
        test_frame();
        test_glitch();
        test_framing();
        test_overrun();
        test_full_pop();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
